// File: rtl/codificador_mensajes_tx.sv
// Formats LETRA/VALOR/SENTIDO as "<letter><decimal digits><terminator>" and
// streams the frame byte by byte into a UART transmitter over wr_en/tx_busy.
module codificador_mensajes_tx #(
  parameter logic [7:0] CARACTER_TERMINACION       = 8'd35,
  parameter logic [7:0] CARACTER_TERMINACION_ATRAS = 8'd33,
  parameter logic [7:0] ASCII_CERO                 = 8'd48
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       enviar,
  input  logic [7:0] LETRA,
  input  logic [7:0] VALOR,
  input  logic       SENTIDO,
  input  logic       tx_busy,
  output logic       wr_en,
  output logic [7:0] din,
  output logic       ocupado,
  output logic       listo
);

  typedef enum logic [2:0] {
    REPOSO, CONVERTIR, CARGAR, ENVIAR, ESPERA_ALTO, ESPERA_BAJO, FIN
  } estado_t;

  estado_t         estado_reg, estado_next;
  logic [7:0]      letra_reg, letra_next;
  logic [7:0]      resto_reg, resto_next;
  logic [3:0]      centenas_reg, centenas_next;
  logic [3:0]      decenas_reg, decenas_next;
  logic            sentido_reg, sentido_next;
  logic [4:0][7:0] bytes_reg, bytes_next;
  logic [2:0]      n_reg, n_next;
  logic [2:0]      idx_reg, idx_next;
  logic            wr_en_reg, wr_en_next;
  logic [7:0]      din_reg, din_next;
  logic            ocupado_reg, ocupado_next;
  logic            listo_reg, listo_next;
  logic [2:0]      pos;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      estado_reg   <= REPOSO;
      letra_reg    <= '0;
      resto_reg    <= '0;
      centenas_reg <= '0;
      decenas_reg  <= '0;
      sentido_reg  <= 1'b0;
      bytes_reg    <= '0;
      n_reg        <= '0;
      idx_reg      <= '0;
      wr_en_reg    <= 1'b0;
      din_reg      <= '0;
      ocupado_reg  <= 1'b0;
      listo_reg    <= 1'b0;
    end else begin
      estado_reg   <= estado_next;
      letra_reg    <= letra_next;
      resto_reg    <= resto_next;
      centenas_reg <= centenas_next;
      decenas_reg  <= decenas_next;
      sentido_reg  <= sentido_next;
      bytes_reg    <= bytes_next;
      n_reg        <= n_next;
      idx_reg      <= idx_next;
      wr_en_reg    <= wr_en_next;
      din_reg      <= din_next;
      ocupado_reg  <= ocupado_next;
      listo_reg    <= listo_next;
    end
  end

  always_comb begin
    estado_next   = estado_reg;
    letra_next    = letra_reg;
    resto_next    = resto_reg;
    centenas_next = centenas_reg;
    decenas_next  = decenas_reg;
    sentido_next  = sentido_reg;
    bytes_next    = bytes_reg;
    n_next        = n_reg;
    idx_next      = idx_reg;
    wr_en_next    = 1'b0;
    din_next      = din_reg;
    ocupado_next  = ocupado_reg;
    listo_next    = 1'b0;
    pos           = 3'd1;

    unique case (estado_reg)
      REPOSO: begin
        if (enviar) begin
          letra_next    = LETRA;
          resto_next    = VALOR;
          sentido_next  = SENTIDO;
          centenas_next = '0;
          decenas_next  = '0;
          ocupado_next  = 1'b1;
          estado_next   = CONVERTIR;
        end
      end
      CONVERTIR: begin
        // Hundreds are exhausted first, so resto<100 whenever the tens branch runs.
        if (resto_reg >= 8'd100) begin
          resto_next    = resto_reg - 8'd100;
          centenas_next = centenas_reg + 4'd1;
        end else if (resto_reg >= 8'd10) begin
          resto_next   = resto_reg - 8'd10;
          decenas_next = decenas_reg + 4'd1;
        end else begin
          estado_next = CARGAR;
        end
      end
      CARGAR: begin
        bytes_next[0] = letra_reg;
        if (centenas_reg != 4'd0) begin
          bytes_next[pos] = {4'd0, centenas_reg} + ASCII_CERO;
          pos = pos + 3'd1;
        end
        if ((centenas_reg != 4'd0) || (decenas_reg != 4'd0)) begin
          bytes_next[pos] = {4'd0, decenas_reg} + ASCII_CERO;
          pos = pos + 3'd1;
        end
        bytes_next[pos] = resto_reg + ASCII_CERO;
        pos = pos + 3'd1;
        bytes_next[pos] = sentido_reg ? CARACTER_TERMINACION : CARACTER_TERMINACION_ATRAS;
        n_next      = pos + 3'd1;
        idx_next    = 3'd0;
        estado_next = ENVIAR;
      end
      ENVIAR: begin
        if (!tx_busy) begin
          din_next    = bytes_reg[idx_reg];
          wr_en_next  = 1'b1;
          estado_next = ESPERA_ALTO;
        end
      end
      ESPERA_ALTO: estado_next = ESPERA_BAJO;
      ESPERA_BAJO: begin
        if (!tx_busy) begin
          if (idx_reg == n_reg - 3'd1) begin
            listo_next   = 1'b1;
            ocupado_next = 1'b0;
            estado_next  = FIN;
          end else begin
            idx_next    = idx_reg + 3'd1;
            estado_next = ENVIAR;
          end
        end
      end
      FIN: estado_next = REPOSO;
      default: estado_next = REPOSO;
    endcase
  end

  assign wr_en   = wr_en_reg;
  assign din     = din_reg;
  assign ocupado = ocupado_reg;
  assign listo   = listo_reg;

endmodule

// File: tb/tb_codificador_mensajes_tx.sv
// Directed bench for codificador_mensajes_tx with a simple UART TX busy model.
module tb_codificador_mensajes_tx;

  logic       CLOCK_50 = 1'b0;
  logic       RESET = 1'b1;
  logic       enviar = 1'b0;
  logic [7:0] LETRA = 8'h00;
  logic [7:0] VALOR = 8'h00;
  logic       SENTIDO = 1'b0;
  logic       tx_busy;
  logic       wr_en;
  logic [7:0] din;
  logic       ocupado;
  logic       listo;

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  int  busy_cnt = 0;
  int  viol = 0;
  int  wide = 0;
  logic prev_wr = 1'b0;
  logic force_busy = 1'b0;

  codificador_mensajes_tx dut (
    .CLOCK_50(CLOCK_50),
    .RESET(RESET),
    .enviar(enviar),
    .LETRA(LETRA),
    .VALOR(VALOR),
    .SENTIDO(SENTIDO),
    .tx_busy(tx_busy),
    .wr_en(wr_en),
    .din(din),
    .ocupado(ocupado),
    .listo(listo)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  assign tx_busy = (busy_cnt != 0) || force_busy;

  // TX model: each accepted byte keeps the transmitter busy for 10 cycles.
  always @(negedge CLOCK_50) begin
    if (wr_en) begin
      if (tx_busy) viol++;
      if (prev_wr) wide++;
      q.push_back(din);
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    prev_wr = wr_en;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] l, input logic [7:0] v,
                           input logic s, input int nexp, input logic [39:0] exp,
                           input bit hold_busy, input bit repulse);
    int base;
    int cyc;
    int first;
    int drops;
    bit got;
    logic [39:0] e;
    base  = q.size();
    cyc   = 0;
    first = -1;
    drops = 0;
    got   = 0;
    e     = exp;
    @(negedge CLOCK_50);
    if (hold_busy) force_busy = 1'b1;
    LETRA = l; VALOR = v; SENTIDO = s; enviar = 1'b1;
    @(negedge CLOCK_50);
    enviar = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLOCK_50);
      cyc++;
      if (first < 0 && q.size() > base) first = cyc;
      if (hold_busy && cyc == 50) begin
        chk({tag, "_held_no_strobe"}, q.size() - base, 0);
        force_busy = 1'b0;
      end
      if (repulse && cyc == 20) begin
        VALOR = 8'd99; enviar = 1'b1;
      end
      if (repulse && cyc == 21) enviar = 1'b0;
      if (listo) begin
        got = 1;
        break;
      end
      if (!ocupado) drops++;
    end
    chk({tag, "_listo_seen"}, int'(got), 1);
    chk({tag, "_ocupado_at_listo"}, int'(ocupado), 0);
    chk({tag, "_ocupado_drops"}, drops, 0);
    chk({tag, "_nbytes"}, q.size() - base, nexp);
    for (int k = 0; k < nexp; k++) begin
      if (base + k < q.size())
        chk($sformatf("%s_byte%0d", tag, k), int'(q[base + k]), int'(e[39 - 8*k -: 8]));
    end
    if (!hold_busy && !repulse) chk({tag, "_latency_le14"}, int'(first >= 0 && first <= 14), 1);
    @(negedge CLOCK_50);
    chk({tag, "_listo_one_cycle"}, int'(listo), 0);
    $display("frame %s: LETRA=0x%0h VALOR=%0d SENTIDO=%0d bytes=%0d first_wr=%0d",
             tag, l, v, s, q.size() - base, first);
  endtask

  initial begin
    int base2;
    int cnt;
    #1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_din", int'(din), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_listo", int'(listo), 0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET = 1'b0;

    run_frame("A200", 8'h41, 8'd200, 1'b1, 5, 40'h41_32_30_30_23, 0, 0);
    run_frame("A0",   8'h41, 8'd0,   1'b0, 3, 40'h41_30_21_00_00, 0, 0);
    run_frame("A7",   8'h41, 8'd7,   1'b1, 3, 40'h41_37_23_00_00, 0, 0);
    run_frame("A45",  8'h41, 8'd45,  1'b1, 4, 40'h41_34_35_23_00, 0, 0);
    run_frame("A255", 8'h41, 8'd255, 1'b1, 5, 40'h41_32_35_35_23, 0, 0);
    run_frame("M199", 8'h4D, 8'd199, 1'b0, 5, 40'h4D_31_39_39_21, 0, 0);
    run_frame("busy", 8'h42, 8'd10,  1'b1, 4, 40'h42_31_30_23_00, 1, 0);
    run_frame("repulse", 8'h50, 8'd150, 1'b1, 5, 40'h50_31_35_30_23, 0, 1);

    // Abort a frame after its second byte.
    base2 = q.size();
    @(negedge CLOCK_50);
    LETRA = 8'h53; VALOR = 8'd123; SENTIDO = 1'b1; enviar = 1'b1;
    @(negedge CLOCK_50);
    enviar = 1'b0;
    cnt = 0;
    while (q.size() - base2 < 2 && cnt < 500) begin
      @(negedge CLOCK_50);
      cnt++;
    end
    chk("abort_two_bytes_seen", int'(cnt < 500), 1);
    #2 RESET = 1'b1;
    #1;
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_ocupado", int'(ocupado), 0);
    chk("abort_listo", int'(listo), 0);
    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b0;
    base2 = q.size();
    repeat (40) @(negedge CLOCK_50);
    chk("abort_no_more_strobes", q.size() - base2, 0);
    chk("abort_ocupado_idle", int'(ocupado), 0);
    $display("frame abort: bytes_before_reset=2 strobes_after=%0d", q.size() - base2);

    run_frame("Z123", 8'h5A, 8'd123, 1'b0, 5, 40'h5A_31_32_33_21, 0, 0);

    chk("wr_en_while_busy", viol, 0);
    chk("wr_en_single_cycle", wide, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
